// File: rtl/koa_pipe_mult_if.sv
// ---------------------------------------------------------------------------
// koa_pipe_mult_if -- operand/product handshake bundle for koa_pipe_mult.
//
// Parameters:
//   SW            operand width in bits
// Signals (directions as seen from the multiplier, modport slave):
//   valid_i       in   operand pair on Data_A_i/Data_B_i is valid
//   ready_o       out  multiplier accepts operands this cycle
//   Data_A_i      in   multiplicand, unsigned, SW bits
//   Data_B_i      in   multiplier, unsigned, SW bits
//   flush_i       in   synchronous pipeline flush
//   valid_o       out  sgf_result_o holds a valid product
//   ready_i       in   downstream accepts the product this cycle
//   sgf_result_o  out  product, 2*SW bits
//   busy_o        out  at least one stage holds a valid operation
// The master modport is the mirror image, for the producer/consumer side.
// ---------------------------------------------------------------------------
interface koa_pipe_mult_if #(
  parameter int SW = 24
);
  logic            valid_i;
  logic            ready_o;
  logic [SW-1:0]   Data_A_i;
  logic [SW-1:0]   Data_B_i;
  logic            flush_i;
  logic            valid_o;
  logic            ready_i;
  logic [2*SW-1:0] sgf_result_o;
  logic            busy_o;

  modport slave (
    input  valid_i, Data_A_i, Data_B_i, flush_i, ready_i,
    output ready_o, valid_o, sgf_result_o, busy_o
  );

  modport master (
    output valid_i, Data_A_i, Data_B_i, flush_i, ready_i,
    input  ready_o, valid_o, sgf_result_o, busy_o
  );
endinterface

// File: rtl/koa_pipe_mult.sv
// ---------------------------------------------------------------------------
// koa_pipe_mult -- three-stage, one-level Karatsuba significand multiplier.
//
// Computes the unsigned SW x SW product at one result per cycle, 3 cycles of
// latency, with valid/ready flow control (whole-pipeline stall, no bubble
// compression) and a synchronous flush.
//
// Parameters:
//   SW          operand width, 4..64, odd or even
//   RESET_DATA  1: datapath registers cleared by reset; 0: only valid bits
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-high reset
//   bus   koa_pipe_mult_if.slave (operand handshake, flush, product
//         handshake, busy)
//
// Split: L = ceil(SW/2) low bits, H = floor(SW/2) high bits.
//   S1: AH, AL, BH, BL, SA = AH+AL, SB = BH+BL
//   S2: PH = AH*BH, PL = AL*BL, PM = SA*SB
//   S3: (PH << 2L) + ((PM - PH - PL) << L) + PL
// ---------------------------------------------------------------------------
module koa_pipe_mult #(
  parameter int SW         = 24,
  parameter bit RESET_DATA = 1'b0
) (
  input logic            clk,
  input logic            rst,
  koa_pipe_mult_if.slave bus
);
  localparam int L  = SW - SW / 2;
  localparam int H  = SW / 2;
  localparam int RW = 2 * SW;
  localparam int MW = 2 * L + 2;

  typedef struct packed {
    logic [H-1:0] ah;
    logic [H-1:0] bh;
    logic [L-1:0] al;
    logic [L-1:0] bl;
    logic [L:0]   sa;
    logic [L:0]   sb;
  } s1_t;

  typedef struct packed {
    logic [2*H-1:0] ph;
    logic [2*L-1:0] pl;
    logic [MW-1:0]  pm;
  } s2_t;

  typedef struct packed {
    s1_t           s1;
    s2_t           s2;
    logic [RW-1:0] res;
  } pipe_t;

  logic          v1, v2, v3;
  logic          en;
  pipe_t         pipe_q, pipe_d;
  logic [MW-1:0] mid;

  // The whole pipeline advances together; it only stalls when the output
  // stage is full and downstream refuses it.
  assign en          = ~v3 | bus.ready_i;
  assign bus.ready_o = en & ~bus.flush_i;
  assign bus.valid_o = v3;
  assign bus.busy_o  = v1 | v2 | v3;
  assign bus.sgf_result_o = pipe_q.res;

  always_comb begin
    // NOTE: default-assign everything an always_comb writes so no path
    // leaves a variable unassigned and infers a latch.
    pipe_d = pipe_q;
    mid    = '0;

    // Stage 1: split operands and form the half sums (one carry bit wide).
    pipe_d.s1.ah = bus.Data_A_i[SW-1:L];
    pipe_d.s1.al = bus.Data_A_i[L-1:0];
    pipe_d.s1.bh = bus.Data_B_i[SW-1:L];
    pipe_d.s1.bl = bus.Data_B_i[L-1:0];
    pipe_d.s1.sa = (L+1)'(bus.Data_A_i[SW-1:L]) + (L+1)'(bus.Data_A_i[L-1:0]);
    pipe_d.s1.sb = (L+1)'(bus.Data_B_i[SW-1:L]) + (L+1)'(bus.Data_B_i[L-1:0]);

    // Stage 2: the three leaf products.
    pipe_d.s2.ph = (2*H)'(pipe_q.s1.ah) * (2*H)'(pipe_q.s1.bh);
    pipe_d.s2.pl = (2*L)'(pipe_q.s1.al) * (2*L)'(pipe_q.s1.bl);
    pipe_d.s2.pm = MW'(pipe_q.s1.sa) * MW'(pipe_q.s1.sb);

    // Stage 3: recombine. PM - PH - PL = AH*BL + AL*BH, never negative.
    // The exact product fits in RW bits, so summing modulo 2^RW loses
    // nothing: the carry out of bit RW-1 is always zero.
    mid = pipe_q.s2.pm - MW'(pipe_q.s2.ph) - MW'(pipe_q.s2.pl);
    pipe_d.res = (RW'(pipe_q.s2.ph) << (2 * L))
               + (RW'(mid) << L)
               + RW'(pipe_q.s2.pl);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {v1, v2, v3} <= 3'b000;
    end else if (bus.flush_i) begin
      {v1, v2, v3} <= 3'b000;
    end else if (en) begin
      v1 <= bus.valid_i & bus.ready_o;
      v2 <= v1;
      v3 <= v2;
    end
  end

  if (RESET_DATA) begin : g_rst_data
    always_ff @(posedge clk or posedge rst) begin
      if (rst)     pipe_q <= '0;
      else if (en) pipe_q <= pipe_d;
    end
  end else begin : g_no_rst_data
    // NOTE: datapath registers carry no reset; the valid bits alone say
    // whether their contents mean anything.
    always_ff @(posedge clk) begin
      if (en) pipe_q <= pipe_d;
    end
  end
endmodule

// File: tb/tb_koa_pipe_mult.sv
// ---------------------------------------------------------------------------
// tb_koa_pipe_mult -- self-checking bench for koa_pipe_mult.
//
// Two instances: SW=24 with RESET_DATA=1 and SW=7 (odd split) with
// RESET_DATA=0. Directed product tables, backpressure, flush, asynchronous
// reset mid-operation and a random valid/ready stream against A*B.
// ---------------------------------------------------------------------------
module tb_koa_pipe_mult;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  koa_pipe_mult_if #(.SW(24)) b24 ();
  koa_pipe_mult_if #(.SW(7))  b7 ();

  koa_pipe_mult #(.SW(24), .RESET_DATA(1'b1)) dut24 (.clk(clk), .rst(rst), .bus(b24));
  koa_pipe_mult #(.SW(7),  .RESET_DATA(1'b0)) dut7  (.clk(clk), .rst(rst), .bus(b7));

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic [47:0] p;
  } vec24_t;

  typedef struct {
    logic [6:0]  a;
    logic [6:0]  b;
    logic [13:0] p;
  } vec7_t;

  vec24_t      t24[5];
  vec7_t       t7[5];
  logic [23:0] op_a[$];
  logic [23:0] op_b[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a stream of op_a/op_b through the SW=24 instance and score every
  // transfer against A*B in acceptance order. rnd=0: ready held high except
  // a 4-cycle stall as soon as the first product appears. rnd=1: random
  // valid_i and ready_i.
  task automatic stream24(input bit rnd, input int budget);
    logic [47:0] exp_q[$];
    logic [47:0] held;
    int n = op_a.size();
    int sent = 0, got = 0, extra = 0, stall_left = 0;
    bit stalled = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < budget && got < n; cyc++) begin
      if (!rnd && !stalled && b24.valid_o) begin
        stalled    = 1'b1;
        stall_left = 4;
        held       = b24.sgf_result_o;
      end
      b24.valid_i  = (sent < n) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      b24.Data_A_i = (sent < n) ? op_a[sent] : 24'h0;
      b24.Data_B_i = (sent < n) ? op_b[sent] : 24'h0;
      b24.ready_i  = rnd ? ($urandom_range(0, 9) < 7) : (stall_left == 0);
      @(negedge clk);
      if (stall_left > 0) begin
        check("bp_valid_hold", b24.valid_o, 1);
        check("bp_result_hold", b24.sgf_result_o, held);
        check("bp_ready_low", b24.ready_o, 0);
        stall_left--;
      end
      if (b24.valid_i && b24.ready_o) begin
        exp_q.push_back(48'(op_a[sent]) * 48'(op_b[sent]));
        sent++;
      end
      if (b24.valid_o && b24.ready_i) begin
        if (exp_q.size() == 0) extra++;
        else check(rnd ? "rand_prod" : "bp_prod", b24.sgf_result_o, exp_q.pop_front());
        got++;
      end
      @(posedge clk);
      #1;
    end
    b24.valid_i = 1'b0;
    b24.ready_i = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (b24.valid_o) extra++;
      @(posedge clk);
      #1;
    end
    check(rnd ? "rand_count" : "bp_count", got, n);
    check(rnd ? "rand_extra" : "bp_extra", extra, 0);
  endtask

  // Output must hold under backpressure, and the pipeline must never offer
  // to accept while it cannot advance.
  assert property (@(posedge clk) disable iff (rst)
    b24.ready_o |-> (!b24.valid_o || b24.ready_i));
  assert property (@(posedge clk) disable iff (rst)
    (b24.valid_o && !b24.ready_i && !b24.flush_i) |=>
      (b24.valid_o && $stable(b24.sgf_result_o)));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    {b24.valid_i, b24.flush_i, b24.Data_A_i, b24.Data_B_i} = '0;
    {b7.valid_i,  b7.flush_i,  b7.Data_A_i,  b7.Data_B_i}  = '0;
    b24.ready_i = 1'b1;
    b7.ready_i  = 1'b1;

    t24[0] = '{24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001};
    t24[1] = '{24'h800000, 24'h800000, 48'h400000000000};
    t24[2] = '{24'h000000, 24'h123456, 48'h000000000000};
    t24[3] = '{24'h000003, 24'h000005, 48'h00000000000F};
    t24[4] = '{24'h123456, 24'h000010, 48'h000001234560};

    t7[0] = '{7'd127, 7'd127, 14'h3F01};
    t7[1] = '{7'd64,  7'd3,   14'h00C0};
    t7[2] = '{7'd1,   7'd1,   14'h0001};
    t7[3] = '{7'd85,  7'd42,  14'h0DF2};
    t7[4] = '{7'd127, 7'd1,   14'h007F};

    // Reset state.
    #12 rst = 1'b0;
    step();
    check("rst_valid24", b24.valid_o, 0);
    check("rst_busy24", b24.busy_o, 0);
    check("rst_ready24", b24.ready_o, 1);
    check("rst_result24", b24.sgf_result_o, 0);
    check("rst_valid7", b7.valid_o, 0);
    check("rst_ready7", b7.ready_o, 1);

    // Back-to-back directed products, SW=24: vector c appears after edge c+2.
    for (int c = 0; c < 8; c++) begin
      b24.valid_i  = (c < 5);
      b24.Data_A_i = (c < 5) ? t24[c].a : 24'h0;
      b24.Data_B_i = (c < 5) ? t24[c].b : 24'h0;
      step();
      check("t24_valid", b24.valid_o, (c >= 2 && c < 7));
      if (c >= 2 && c < 7) check("t24_prod", b24.sgf_result_o, t24[c-2].p);
    end

    // Same for the odd split, SW=7.
    for (int c = 0; c < 8; c++) begin
      b7.valid_i  = (c < 5);
      b7.Data_A_i = (c < 5) ? t7[c].a : 7'h0;
      b7.Data_B_i = (c < 5) ? t7[c].b : 7'h0;
      step();
      check("t7_valid", b7.valid_o, (c >= 2 && c < 7));
      if (c >= 2 && c < 7) check("t7_prod", b7.sgf_result_o, t7[c-2].p);
    end

    // Backpressure: 5 products, 4-cycle stall once the first appears.
    op_a = {24'h000011, 24'h000123, 24'h00ABCD, 24'h7FFFFF, 24'hFFFFFF};
    op_b = {24'h000022, 24'h000456, 24'h001234, 24'h000002, 24'h000003};
    stream24(1'b0, 100);

    // Flush: three accepted with downstream stalled, flush with a 4th offer.
    b24.ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b24.valid_i  = 1'b1;
      b24.Data_A_i = 24'(i + 1);
      b24.Data_B_i = 24'd7;
      step();
    end
    b24.Data_A_i = 24'd9;
    b24.Data_B_i = 24'd9;
    b24.flush_i  = 1'b1;
    #1;
    check("flush_ready_low", b24.ready_o, 0);
    check("flush_busy_before", b24.busy_o, 1);
    step();
    b24.flush_i = 1'b0;
    b24.valid_i = 1'b0;
    check("flush_valid_cleared", b24.valid_o, 0);
    check("flush_busy_cleared", b24.busy_o, 0);
    b24.ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("flush_no_stale", b24.valid_o, 0);
    end
    b24.valid_i  = 1'b1;
    b24.Data_A_i = 24'd3;
    b24.Data_B_i = 24'd5;
    step();
    b24.valid_i = 1'b0;
    step();
    check("post_flush_latency", b24.valid_o, 0);
    step();
    check("post_flush_valid", b24.valid_o, 1);
    check("post_flush_prod", b24.sgf_result_o, 15);
    step();

    // Asynchronous reset with products in flight.
    for (int i = 0; i < 3; i++) begin
      b24.valid_i  = 1'b1;
      b24.Data_A_i = 24'h111111 + 24'(i);
      b24.Data_B_i = 24'd2;
      step();
    end
    b24.valid_i = 1'b0;
    check("pre_rst_valid", b24.valid_o, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", b24.valid_o, 0);
    check("async_rst_busy", b24.busy_o, 0);
    check("async_rst_result", b24.sgf_result_o, 0);
    #3 rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("post_rst_no_stale", b24.valid_o, 0);
    end
    check("post_rst_ready", b24.ready_o, 1);

    // Random valid_i/ready_i stream.
    op_a.delete();
    op_b.delete();
    for (int i = 0; i < 400; i++) begin
      op_a.push_back(24'($urandom));
      op_b.push_back(24'($urandom));
    end
    stream24(1'b1, 4000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
